// File: rtl/quant_block_sequencer_if.sv
// Row handshake bundle between the DCT clipping output, the sequencer and the downstream coder.
// master = environment side, slave = sequencer side.
interface quant_block_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int DIM   = 8
);
    localparam int IDX_W = $clog2(DIM);

    logic                   in_valid;
    logic                   in_ready;
    logic [DIM*WIDTH-1:0]   in_row;
    logic                   out_valid;
    logic                   out_ready;
    logic [DIM*WIDTH-1:0]   out_row;
    logic [IDX_W-1:0]       out_row_idx;
    logic                   out_last_row;
    logic                   out_last_blk;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, out_last_row, out_last_blk
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, out_last_row, out_last_blk
    );
endinterface

// File: rtl/quant_block_sequencer.sv
// Two-stage row sequencer around the combinational quantization stage for one compression job.
// Optional all-zero row flag and counter enabled by defining QUANT_ZERO_ROW_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start, input closed
// RUN   | accepting rows until the last row of the job is taken
// DRAIN | input closed, flushing S1/S2 downstream
// DONE  | single-cycle done pulse, then back to IDLE
module quant_block_sequencer #(
    parameter int WIDTH     = 16,
    parameter int DIM       = 8,
    parameter int BLK_CNT_W = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [BLK_CNT_W-1:0]          num_blocks_i,
    output logic [DIM*WIDTH-1:0]          q_in_o,
    input  logic [DIM*WIDTH-1:0]          q_out_i,
    quant_block_sequencer_if.slave        bus,
`ifdef QUANT_ZERO_ROW_FLAG_EN
    output logic                          out_zero_row_o,
    output logic [BLK_CNT_W+$clog2(DIM)-1:0] zero_row_cnt_o,
`endif
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int IDX_W = $clog2(DIM);
    localparam int DW    = DIM * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [BLK_CNT_W-1:0]   nblk_q;
    logic [BLK_CNT_W-1:0]   blk_cnt_q;
    logic [BLK_CNT_W-1:0]   blk_cnt_d;
    logic [IDX_W-1:0]       row_cnt_q;
    logic [IDX_W-1:0]       row_cnt_d;

    logic                   s1_v_q;
    logic [DW-1:0]          q_in_q;
    logic [IDX_W-1:0]       s1_idx_q;
    logic                   s1_lr_q;
    logic                   s1_lb_q;

    logic                   s2_v_q;
    logic [DW-1:0]          out_row_q;
    logic [IDX_W-1:0]       s2_idx_q;
    logic                   s2_lr_q;
    logic                   s2_lb_q;

`ifdef QUANT_ZERO_ROW_FLAG_EN
    localparam int ZC_W = BLK_CNT_W + $clog2(DIM);
    logic                   zero_q;
    logic [ZC_W-1:0]        zero_cnt_q;
`endif

    logic s2_load, s1_adv, s1_load, in_ready, in_acc, out_acc, last_row_in, last_in;

    // in_ready sees out_ready only through the valid bits, never through data.
    always_comb begin
        s2_load     = !s2_v_q || bus.out_ready;
        s1_adv      = s1_v_q && s2_load;
        s1_load     = !s1_v_q || s1_adv;
        in_ready    = (state_q == RUN) && s1_load;
        in_acc      = bus.in_valid && in_ready;
        out_acc     = s2_v_q && bus.out_ready;
        last_row_in = (row_cnt_q == IDX_W'(DIM - 1));
        last_in     = last_row_in && (blk_cnt_q == nblk_q - BLK_CNT_W'(1));
        row_cnt_d   = last_row_in ? '0 : row_cnt_q + IDX_W'(1);
        blk_cnt_d   = last_row_in ? blk_cnt_q + BLK_CNT_W'(1) : blk_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nblk_q    <= '0;
            blk_cnt_q <= '0;
            row_cnt_q <= '0;
            s1_v_q    <= 1'b0;
            q_in_q    <= '0;
            s1_idx_q  <= '0;
            s1_lr_q   <= 1'b0;
            s1_lb_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            out_row_q <= '0;
            s2_idx_q  <= '0;
            s2_lr_q   <= 1'b0;
            s2_lb_q   <= 1'b0;
`ifdef QUANT_ZERO_ROW_FLAG_EN
            zero_q     <= 1'b0;
            zero_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        nblk_q    <= (num_blocks_i == '0) ? BLK_CNT_W'(1) : num_blocks_i;
                        blk_cnt_q <= '0;
                        row_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (in_acc && last_in) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_acc && s2_lb_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            if (in_acc) begin
                row_cnt_q <= row_cnt_d;
                blk_cnt_q <= blk_cnt_d;
            end

            if (s1_load) begin
                s1_v_q <= in_acc;
                if (in_acc) begin
                    q_in_q   <= bus.in_row;
                    s1_idx_q <= row_cnt_q;
                    s1_lr_q  <= last_row_in;
                    s1_lb_q  <= last_in;
                end
            end

            // S2 holds everything while stalled; it only captures when S1 actually hands over.
            if (s2_load) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    out_row_q <= q_out_i;
                    s2_idx_q  <= s1_idx_q;
                    s2_lr_q   <= s1_lr_q;
                    s2_lb_q   <= s1_lb_q;
`ifdef QUANT_ZERO_ROW_FLAG_EN
                    zero_q    <= (q_out_i == '0);
`endif
                end
            end

`ifdef QUANT_ZERO_ROW_FLAG_EN
            if (state_q == IDLE && start_i) begin
                zero_cnt_q <= '0;
            end else if (out_acc && zero_q) begin
                zero_cnt_q <= zero_cnt_q + ZC_W'(1);
            end
`endif
        end
    end

    assign q_in_o           = q_in_q;
    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_v_q;
    assign bus.out_row      = out_row_q;
    assign bus.out_row_idx  = s2_idx_q;
    assign bus.out_last_row = s2_lr_q;
    assign bus.out_last_blk = s2_lb_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
`ifdef QUANT_ZERO_ROW_FLAG_EN
    assign out_zero_row_o   = zero_q;
    assign zero_row_cnt_o   = zero_cnt_q;
`endif
endmodule

// File: tb/tb_quant_block_sequencer.sv
// Randomized job-level bench for quant_block_sequencer against a row-queue reference model.
// Also covers the zero-row flag/counter when QUANT_ZERO_ROW_FLAG_EN is defined.
module tb_quant_block_sequencer;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int BW = 12;
    localparam int DW = D * W;
    localparam int IW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] num_blocks = '0;
    logic [DW-1:0] q_in;
    logic [DW-1:0] q_out;
    logic          busy;
    logic          done;
    logic          quant_neg = 1'b0;
`ifdef QUANT_ZERO_ROW_FLAG_EN
    logic             out_zero_row;
    logic [BW+IW-1:0] zero_row_cnt;
`endif

    int total = 0;
    int bad   = 0;

    quant_block_sequencer_if #(.WIDTH(W), .DIM(D)) bus ();

    quant_block_sequencer #(.WIDTH(W), .DIM(D), .BLK_CNT_W(BW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .num_blocks_i   (num_blocks),
        .q_in_o         (q_in),
        .q_out_i        (q_out),
        .bus            (bus),
`ifdef QUANT_ZERO_ROW_FLAG_EN
        .out_zero_row_o (out_zero_row),
        .zero_row_cnt_o (zero_row_cnt),
`endif
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    // Stand-in quantization stage: identity or element-wise negation.
    function automatic logic [DW-1:0] qmodel(input logic [DW-1:0] row, input logic neg);
        logic [DW-1:0] r;
        r = row;
        if (neg) for (int i = 0; i < D; i++) r[i*W +: W] = -row[i*W +: W];
        return r;
    endfunction

    always_comb q_out = qmodel(q_in, quant_neg);

    typedef struct {
        logic [DW-1:0] row;
        int            idx;
        bit            lr;
        bit            lb;
        bit            zero;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pattern 0: random, 1: every element 0x10*(r+1), 2: random with rows 2 and 5 all-zero
    function automatic logic [DW-1:0] gen_row(input int pattern, input int k);
        logic [DW-1:0] r;
        int rr;
        rr = k % D;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        if (pattern == 1) for (int i = 0; i < D; i++) r[i*W +: W] = W'(16 * (rr + 1));
        if (pattern == 2 && (rr == 2 || rr == 5)) r = '0;
        return r;
    endfunction

    task automatic run_job(input int cfg, input int in_mode, input int out_mode, input int pattern,
                           input int inject_at, input int abort_after, input bit check_lat);
        int jobrows, accepted, delivered, zero_seen, in_flight;
        bit exp_done, done_seen, stall, aborted;
        logic [DW-1:0] cur_row, held_row, held_tags;
        exp_t e;
        expq.delete();
        jobrows = ((cfg == 0) ? 1 : cfg) * D;
        accepted = 0; delivered = 0; zero_seen = 0; in_flight = 0;
        exp_done = 0; done_seen = 0; stall = 0; aborted = 0;
        held_row = '0; held_tags = '0;
        cur_row = gen_row(pattern, 0);

        @(negedge clk);
        start = 1'b1; num_blocks = BW'(cfg); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1 check("busy before start", busy, 0);

        for (int cyc = 1; cyc < 600; cyc++) begin
            @(negedge clk);
            start = (cyc == inject_at);
            num_blocks = start ? BW'(5) : BW'($urandom);
            bus.in_valid  = (in_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_row    = cur_row;
            bus.out_ready = (out_mode == 0) ? 1'b1 :
                            (out_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 1) check("busy after start", busy, 1);
            check("done pulse", done, exp_done);
            if (exp_done) done_seen = 1;
            if (stall) begin
                check("stall valid", bus.out_valid, 1);
                check("stall row", bus.out_row, held_row);
                check("stall tags", {bus.out_row_idx, bus.out_last_row, bus.out_last_blk}, held_tags);
            end
            if (in_flight == 2 && !bus.out_ready) check("in_ready pipe full", bus.in_ready, 0);
            if (accepted == jobrows) check("in_ready after last", bus.in_ready, 0);

            if (bus.in_valid && bus.in_ready) begin
                e.row  = qmodel(cur_row, quant_neg);
                e.idx  = accepted % D;
                e.lr   = (accepted % D) == D - 1;
                e.lb   = accepted == jobrows - 1;
                e.zero = (e.row == '0);
                expq.push_back(e);
                accepted++;
                cur_row = gen_row(pattern, accepted);
            end

            exp_done = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected output", bus.out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    check("out row", bus.out_row, e.row);
                    check("out idx", bus.out_row_idx, e.idx);
                    check("out last_row", bus.out_last_row, e.lr);
                    check("out last_blk", bus.out_last_blk, e.lb);
`ifdef QUANT_ZERO_ROW_FLAG_EN
                    check("zero flag", out_zero_row, e.zero);
                    if (e.zero) zero_seen++;
`endif
                    if (check_lat) check("output cycle", cyc, 3 + delivered);
                    delivered++;
                    exp_done = e.lb;
                end
            end
            in_flight = accepted - delivered;
            stall = bus.out_valid && !bus.out_ready;
            held_row  = bus.out_row;
            held_tags = {bus.out_row_idx, bus.out_last_row, bus.out_last_blk};

            if (abort_after >= 0 && accepted == abort_after) begin
                aborted = 1;
                break;
            end
            if (done_seen) begin
`ifdef QUANT_ZERO_ROW_FLAG_EN
                check("zero_row_cnt at done", zero_row_cnt, zero_seen);
`endif
                break;
            end
        end

        if (!aborted) begin
            check("job finished in budget", done_seen, 1);
            check("rows accepted", accepted, jobrows);
            check("rows delivered", delivered, jobrows);
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check("busy after done", busy, 0);
            check("done single pulse", done, 0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_row", bus.out_row, 0);
        check("reset q_in", q_in, 0);
        check("reset tags", {bus.out_row_idx, bus.out_last_row, bus.out_last_blk}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);

        // single block, ramp rows, identity, full throughput with latency check
        run_job(1, 0, 0, 1, -1, -1, 1'b1);

        // two blocks under toggling backpressure, negating quantizer
        quant_neg = 1'b1;
        run_job(2, 0, 1, 0, -1, -1, 1'b0);

        // zero block count behaves as one block
        run_job(0, 0, 0, 0, -1, -1, 1'b0);

        // start with a new count mid-job is ignored
        run_job(2, 1, 2, 0, 4, -1, 1'b0);

        // reset after three accepted rows, then a clean job
        run_job(1, 0, 0, 0, -1, 3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post-rst out_valid", bus.out_valid, 0);
        check("post-rst busy", busy, 0);
        check("post-rst in_ready", bus.in_ready, 0);
        check("post-rst done", done, 0);
        check("post-rst out_row", bus.out_row, 0);
        run_job(1, 0, 0, 0, -1, -1, 1'b1);

        // longer random job
        run_job(3, 1, 2, 0, -1, -1, 1'b0);

        // rows 2 and 5 all-zero
        run_job(1, 0, 0, 2, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quant_block_sequencer.md
Name: quant_block_sequencer

Overview:
- Sequences row traffic from the 2D-DCT clipping output through the combinational quantization stage for one compression job.
- Accepts DIM-wide coefficient rows with valid/ready, registers them, presents them to the quantization stage and captures its result.
- Emits quantized rows with row index and end-of-block/end-of-job markers.
- Counts rows and 8x8 blocks, signals job completion, and applies backpressure end to end.

Parameters:
- WIDTH, 16, coefficient width in bits (signed).
- DIM, 8, coefficients per row and rows per block.
- BLK_CNT_W, 12, width of block-count configuration and counter.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a job; ignored unless state is IDLE
- num_blocks  in  BLK_CNT_W  blocks in job, sampled on accepted start; 0 treated as 1
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid & in_ready
- in_row  in  DIM*WIDTH  clipped row, element i at bits [i*WIDTH +: WIDTH]
- q_in  out  DIM*WIDTH  registered row driven to quantization stage
- q_out  in  DIM*WIDTH  quantization stage result (combinational from q_in)
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accept
- out_row  out  DIM*WIDTH  quantized row
- out_row_idx  out  $clog2(DIM)  row index within block
- out_last_row  out  1  high with row DIM-1 of each block
- out_last_blk  out  1  high with final row of job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final row accepted downstream

Behaviour:
- Reset values: in_ready=0, out_valid=0, q_in=0, out_row=0, out_row_idx=0, out_last_row=0, out_last_blk=0, busy=0, done=0, all counters 0, state IDLE.
- States: IDLE -> RUN on start; RUN -> DRAIN when last input row of job accepted; DRAIN -> DONE when last output row accepted; DONE -> IDLE after one cycle. DONE asserts done for exactly that cycle.
- Pipeline has two registered stages:
  - S1 holds q_in and its tags.
  - S2 holds out_row = q_out sampled from S1, plus tags.
- Latency: row accepted at cycle N appears on out_row at N+2 with no stall.
- Stage advance:
  - S2 loads when S2 is empty or out_ready.
  - S1 loads when S1 is empty or S1 advances.
  - in_ready = (state==RUN) & (S1 empty | S1 advancing). Combinational from out_ready through the valid bits only.
- Throughput: one row per cycle with out_ready held high.
- Stall: out_valid, out_row and tags hold stable while out_valid & !out_ready.
- Counters:
  - row_cnt increments per accepted input and wraps DIM-1 -> 0.
  - blk_cnt increments on wrap.
  - The last input is row_cnt==DIM-1 and blk_cnt==num_blocks_latched-1. After it, in_ready=0.
  - row index and last flags travel with the data through S1/S2.
- In IDLE, DRAIN and DONE, in_ready=0 and input is ignored.
- start is ignored while busy. The latched num_blocks is unaffected mid-job.
- Simultaneous S2 unload and S1 advance in one cycle is lossless: no bubble, no duplicate.
- rst mid-job: pipeline contents are discarded, all outputs return to reset values next cycle, no done pulse.
- Arithmetic: no arithmetic on data. Widths pass through unchanged and signed values are preserved bit-exact.

Optional Feature:
- Macro QUANT_ZERO_ROW_FLAG_EN.
- Defined: adds output out_zero_row (1 bit, reset 0), registered alongside S2. It is high when every element of out_row equals 0, for use by run-length coding downstream.
- Defined: adds output zero_row_cnt (BLK_CNT_W+$clog2(DIM) bits), which counts accepted all-zero output rows in the current job and clears on accepted start.
- Not defined: neither port exists and there is no extra logic.

Test Plan:
- Single block, num_blocks=1, in_valid and out_ready held high, rows valued 0x0010*(r+1) with identity quantization -> 8 outputs on consecutive cycles, first at start+3. out_row_idx runs 0..7, out_last_row and out_last_blk both high on row 7, done pulses one cycle after the row-7 handshake.
- Backpressure with num_blocks=2: out_ready toggles 1/0 every cycle -> all 16 rows delivered in order with none lost or duplicated. Data is stable during stall cycles. in_ready drops within one cycle of S1 and S2 both full.
- num_blocks=0 -> behaves as 1 block, exactly 8 rows accepted, then in_ready=0 while in_valid stays high.
- start asserted during RUN with num_blocks changed to 5 -> ignored, original count completes, done pulses once.
- rst pulsed after 3 of 8 rows accepted -> next cycle out_valid=0, busy=0, in_ready=0. A new start with 1 block then yields clean row indices 0..7.
- With QUANT_ZERO_ROW_FLAG_EN defined, feed 8 rows with rows 2 and 5 all-zero -> out_zero_row is high only on those outputs and zero_row_cnt=2 at done.
